param_alu: RTL and testbench
============================

PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width (legal 4..32).
REQ-002 SHALL have parameter MULT_STAGES, default 3, multiply latency in cycles (legal 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a, b  input  WIDTH  operands.
REQ-006 SHALL have port op  input  3  opcode: 000 NOP, 001 ADD, 010 AND, 011 XOR, 100 MUL, 101 SUB, 110/111 reserved.
REQ-007 SHALL have port start  input  1  request; sampled only when busy=0.
REQ-008 SHALL have port busy  output  1  operation in flight.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port result  output  2*WIDTH  result, held between done pulses.
REQ-011 SHALL have port illegal  output  1  one-cycle pulse, coincident with done, for reserved opcode.
REQ-012 SHALL have ports zero, carry  output  1 each  result flags (see REQ-026).

Function
REQ-013 SHALL accept an operation at edge N when start=1, busy=0, op!=NOP, latching a, b, op.
REQ-014 SHALL ignore start when op=NOP or busy=1; no done, no state change.
REQ-015 SHALL use FSM states IDLE, EXEC, DONE: IDLE->EXEC on accept; EXEC->DONE when latency counter expires; DONE->IDLE unconditionally.
REQ-016 SHALL assert busy from the cycle after accept until done asserts, inclusive of the done cycle.
REQ-017 SHALL assert done for exactly one cycle, at edge N+1 for ADD/AND/XOR/SUB/reserved, N+MULT_STAGES for MUL.
REQ-018 SHALL update result on the same edge done rises, never otherwise.
REQ-019 ADD SHALL give zero-extended a+b; carry-out lands in bit WIDTH.
REQ-020 SUB SHALL give a-b in bits WIDTH-1:0, borrow in bit WIDTH, upper bits 0.
REQ-021 AND/XOR SHALL give bitwise result zero-extended to 2*WIDTH.
REQ-022 MUL SHALL give the full unsigned 2*WIDTH product.
REQ-023 Reserved opcodes SHALL complete after 1 cycle with result 0 and illegal=1.
REQ-024 Accepting start in the IDLE cycle following DONE SHALL be legal (back-to-back issue, one dead cycle minimum).

Reset
REQ-025 Asserting reset_n=0 at any time SHALL immediately force IDLE, busy=0, done=0, illegal=0, result=0, zero=0, carry=0, and discard any in-flight operation (no later done).

Configuration
REQ-026 With PARAM_ALU_FLAGS_EN defined: zero=1 iff new result==0 and carry=result[WIDTH] for ADD/SUB (else 0), both registered with done and held; without it: zero and carry SHALL be constant 0 and no flag logic synthesised.

Structure
REQ-027 Package alu_pkg SHALL hold the opcode enum typedef, the FSM state enum typedef, and constants for opcode encodings.
REQ-028 Sub-module alu_mult_pipe (parameters WIDTH, MULT_STAGES) SHALL implement the registered multiply pipeline; param_alu SHALL instantiate it once.
REQ-029 Latency counter width SHALL be $clog2(MULT_STAGES+1).

Verification (WIDTH=8, MULT_STAGES=3, flags enabled)
REQ-030 ADD a=0xFF b=0x01 at edge 0 -> done edge 1, result=0x0100, carry=1, zero=0.
REQ-031 MUL a=0xFF b=0xFF at edge 0 -> busy edges 1-3, done edge 3 only, result=0xFE01.
REQ-032 SUB a=0x10 b=0x20 -> result=0x01F0, carry=1; SUB a=0x20 b=0x20 -> result=0x0000, zero=1.
REQ-033 MUL in flight, start ADD at edge 1 -> ignored; single done at edge 3 with 0xFE01; result unchanged edges 1-2.
REQ-034 MUL accepted, reset_n low at edge 2 for one cycle -> busy=0, result=0 immediately; no done ever for that MUL.
REQ-035 op=111 a=0x12 b=0x34 -> done and illegal at edge 1, result=0x0000; op=000 with start -> no done, busy stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for param_alu and its multiply pipeline.
package alu_pkg;

  localparam logic [2:0] OPC_NOP  = 3'b000;
  localparam logic [2:0] OPC_ADD  = 3'b001;
  localparam logic [2:0] OPC_AND  = 3'b010;
  localparam logic [2:0] OPC_XOR  = 3'b011;
  localparam logic [2:0] OPC_MUL  = 3'b100;
  localparam logic [2:0] OPC_SUB  = 3'b101;
  localparam logic [2:0] OPC_RSV6 = 3'b110;
  localparam logic [2:0] OPC_RSV7 = 3'b111;

  typedef enum logic [2:0] {
    OP_NOP  = OPC_NOP,
    OP_ADD  = OPC_ADD,
    OP_AND  = OPC_AND,
    OP_XOR  = OPC_XOR,
    OP_MUL  = OPC_MUL,
    OP_SUB  = OPC_SUB,
    OP_RSV6 = OPC_RSV6,
    OP_RSV7 = OPC_RSV7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_is_reserved(op_e o);
    return (o == OP_RSV6) || (o == OP_RSV7);
  endfunction

endpackage

// File: rtl/alu_mult_pipe.sv
// Registered unsigned multiplier; the product appears MULT_STAGES-1 cycles after
// the operands, so a result register fed from p_o lands it MULT_STAGES cycles later.
module alu_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] p_o
);

  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  assign a_ext = {{WIDTH{1'b0}}, a_i};
  assign b_ext = {{WIDTH{1'b0}}, b_i};
  assign prod  = a_ext * b_ext;

  generate
    if (MULT_STAGES == 1) begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;
      assign p_o = prod;
    end else begin : g_pipe
      logic [2*WIDTH-1:0] stage_q [MULT_STAGES-1];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < MULT_STAGES-1; k++) stage_q[k] <= '0;
        end else begin
          stage_q[0] <= prod;
          for (int k = 1; k < MULT_STAGES-1; k++) stage_q[k] <= stage_q[k-1];
        end
      end

      assign p_o = stage_q[MULT_STAGES-2];
    end
  endgenerate

endmodule

// File: rtl/param_alu.sv
// Multi-cycle parameterised ALU with single-cycle ops and a pipelined multiply.
// Optional result flags are built only when PARAM_ALU_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | waiting for start with a non-NOP opcode
// EXEC  | operation in flight, latency counter running
// DONE  | result valid, done pulse, one dead cycle before next accept
module param_alu
  import alu_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int MULT_STAGES = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               illegal,
  output logic               zero,
  output logic               carry
);

  localparam int CNT_W = $clog2(MULT_STAGES + 1);

  state_e             state_q, state_d;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d, mul_p;
  logic [WIDTH:0]     sum, diff;
  logic               accept, finish;

  assign accept = (state_q == IDLE) && start && (op != OPC_NOP);
  assign finish = (state_q == EXEC) && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    illegal = (state_q == DONE) && op_is_reserved(op_q);
  end

  // Counter holds remaining EXEC cycles minus one; zero means finish this edge.
  always_comb begin
    cnt_d = cnt_q;
    if (accept)
      cnt_d = (op == OPC_MUL) ? CNT_W'(MULT_STAGES - 1) : '0;
    else if ((state_q == EXEC) && (cnt_q != '0))
      cnt_d = cnt_q - CNT_W'(1);
  end

  alu_mult_pipe #(
    .WIDTH       (WIDTH),
    .MULT_STAGES (MULT_STAGES)
  ) u_mult (
    .clk     (clk),
    .reset_n (reset_n),
    .a_i     (a_q),
    .b_i     (b_q),
    .p_o     (mul_p)
  );

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    result_d = '0;
    unique case (op_q)
      OP_ADD:  result_d = {{(WIDTH-1){1'b0}}, sum};
      OP_SUB:  result_d = {{(WIDTH-1){1'b0}}, diff};
      OP_AND:  result_d = {{WIDTH{1'b0}}, a_q & b_q};
      OP_XOR:  result_d = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_MUL:  result_d = mul_p;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NOP;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        a_q  <= a;
        b_q  <= b;
        op_q <= op_e'(op);
      end
      cnt_q <= cnt_d;
      if (finish) result_q <= result_d;
    end
  end

  assign result = result_q;

`ifdef PARAM_ALU_FLAGS_EN
  logic zero_q, carry_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (finish) begin
      zero_q  <= (result_d == '0);
      carry_q <= ((op_q == OP_ADD) || (op_q == OP_SUB)) ? result_d[WIDTH] : 1'b0;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;
`else
  assign zero  = 1'b0;
  assign carry = 1'b0;
`endif

endmodule

// File: tb/tb_param_alu.sv
// Directed plus randomized bench for param_alu (WIDTH=8, MULT_STAGES=3).
module tb_param_alu;

  localparam int W  = 8;
  localparam int MS = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] a, b;
  logic [2:0]   op;
  logic         start;
  logic         busy, done, illegal, zero, carry;
  logic [2*W-1:0] result;

  int checks = 0;
  int errors = 0;

  logic [15:0] last_res;
  logic        exp_z, exp_c;

  param_alu #(.WIDTH(W), .MULT_STAGES(MS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .op      (op),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal),
    .zero    (zero),
    .carry   (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  // Reference: plain arithmetic on integers, 9-bit wrap for SUB gives the borrow bit.
  function automatic logic [15:0] model(input int o, input int x, input int y);
    case (o)
      1:       return 16'(x + y);
      2:       return 16'(x & y);
      3:       return 16'(x ^ y);
      4:       return 16'(x * y);
      5:       return 16'((x - y) & 'h1FF);
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk_flags(input string tag);
`ifdef PARAM_ALU_FLAGS_EN
    chk({tag, "_zero"}, 32'(zero), 32'(exp_z));
    chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
`else
    chk({tag, "_zero_off"}, 32'(zero), 32'd0);
    chk({tag, "_carry_off"}, 32'(carry), 32'd0);
`endif
  endtask

  // Issue one op; optionally hammer start with other requests while busy.
  task automatic run_op(input int o, input int x, input int y, input bit poke);
    logic [15:0] expv;
    int lat;
    expv = model(o, x, y);
    lat  = (o == 4) ? MS : 1;
    a = W'(x); b = W'(y); op = 3'(o); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("done_after_accept", 32'(done), 32'd0);
    for (int k = 1; k <= lat; k++) begin
      if (poke) begin
        start = 1'b1; op = 3'd1; a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      chk("busy_inflight", 32'(busy), 32'd1);
      chk("done_timing", 32'(done), 32'(k == lat));
      chk("illegal_timing", 32'(illegal), 32'((k == lat) && (o >= 6)));
      if (k < lat) begin
        chk("result_held", 32'(result), 32'(last_res));
      end else begin
        chk("result_value", 32'(result), 32'(expv));
        exp_z = (expv == 16'd0);
        exp_c = ((o == 1) || (o == 5)) ? expv[8] : 1'b0;
        chk_flags("done");
      end
    end
    start = 1'b0;
    last_res = expv;
    @(posedge clk); #1;
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_single", 32'(done), 32'd0);
    chk("result_hold_idle", 32'(result), 32'(last_res));
    chk_flags("idle");
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    last_res = 16'd0; exp_z = 1'b0; exp_c = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk_flags("rst");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(1, 'hFF, 'h01, 1'b0);
    run_op(4, 'hFF, 'hFF, 1'b1);
    run_op(5, 'h10, 'h20, 1'b0);

    // Reset while a multiply is in flight: everything clears, no late done.
    a = 8'hFF; b = 8'hFF; op = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    last_res = 16'd0; exp_z = 1'b0; exp_c = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk_flags("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
      chk("midrst_no_busy", 32'(busy), 32'd0);
    end

    run_op(5, 'h20, 'h20, 1'b0);
    run_op(1, 'h37, 'h21, 1'b0);
    run_op(7, 'h12, 'h34, 1'b0);
    run_op(6, 'hAA, 'h55, 1'b1);

    op = 3'd0; a = 8'h5A; b = 8'hA5; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("nop_busy", 32'(busy), 32'd0);
      chk("nop_done", 32'(done), 32'd0);
      chk("nop_result", 32'(result), 32'(last_res));
    end
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      int o, x, y;
      o = $urandom_range(1, 7);
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      if ((i % 8) == 0) begin
        x = 0; y = (o == 5) ? 0 : y;
      end
      run_op(o, x, y, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
